mmio_resp: RTL and testbench

//   Responder on the CPU data-memory bus for a memory-mapped peripheral window.
//   It decodes loads and stores from the rv32 core and serves them from device registers.

---
 rtl/mmio_pkg.sv | 61 ++++++
 rtl/mmio_fifo.sv | 62 ++++++
 rtl/mmio_resp.sv | 161 ++++++++++++++++
 tb/tb_mmio_resp.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the mmio_resp peripheral window: register offsets,
// memop encodings and the load-extend / store-lane helpers also used by dmem.
package mmio_pkg;

    localparam logic [2:0] OFF_KBD_DATA = 3'd0;
    localparam logic [2:0] OFF_KBD_STAT = 3'd1;
    localparam logic [2:0] OFF_TIMER_MS = 3'd2;
    localparam logic [2:0] OFF_LED      = 3'd3;
    localparam logic [2:0] OFF_CYCLE    = 3'd4;
    localparam logic [2:0] OFF_CMP      = 3'd5;

    typedef enum logic [2:0] {
        MOP_LB  = 3'b000,
        MOP_LH  = 3'b001,
        MOP_LW  = 3'b010,
        MOP_LBU = 3'b100,
        MOP_LHU = 3'b101
    } memop_e;

    // Undefined memop codes fall through to a full-word load.
    function automatic logic [31:0] extend(input logic [31:0] word,
                                           input logic [2:0]  memop,
                                           input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (memop)
            MOP_LB:  return {{24{b[7]}}, b};
            MOP_LH:  return {{16{h[15]}}, h};
            MOP_LBU: return {24'b0, b};
            MOP_LHU: return {16'b0, h};
            default: return word;
        endcase
    endfunction

    // size: 00 byte, 01 halfword, otherwise word; store data arrives right-aligned.
    function automatic logic [31:0] storeMerge(input logic [31:0] oldWord,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            2'b00: begin
                mask = 32'h0000_00FF << {lane, 3'b000};
                data = {4{wdata[7:0]}};
            end
            2'b01: begin
                mask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                data = {2{wdata[15:0]}};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = wdata;
            end
        endcase
        return (oldWord & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/mmio_fifo.sv
// Keyboard scan-code FIFO, 8 bits wide. A push while full is accepted only
// when a pop happens in the same cycle; pops while empty are ignored.
module mmio_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW:0]   count_q, count_d;
    logic          doPush, doPop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == (AW+1)'(DEPTH));
    assign count  = count_q;
    assign dout   = mem_q[rdPtr_q];
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
        if (doPush) wrPtr_d = wrPtr_q + 1'b1;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clock) begin
        if (doPush) mem_q[wrPtr_q] <= din;
    end

endmodule

// File: rtl/mmio_resp.sv
// Peripheral window beside dmem: keyboard FIFO, ms timer, cycle counter, LEDs.
// Define MMIO_TIMER_CMP_EN to build the CMP register and timer-compare irq.
module mmio_resp
    import mmio_pkg::*;
#(
    parameter logic [11:0] BASE       = 12'h002,
    parameter int          CLK_HZ     = 50000000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    output logic [31:0] dataout,
    input  logic [2:0]  memop,
    input  logic        we,
    input  logic        re,
    input  logic [7:0]  kbd_code,
    input  logic        kbd_valid,
    output logic [15:0] led,
    output logic        irq
);

    localparam int            PRESC     = CLK_HZ / 1000;
    localparam int            PW        = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC - 1);
    localparam int            CW        = $clog2(FIFO_DEPTH) + 1;

    logic          sel, rdEn, wrEn, timerWr, tick;
    logic [2:0]    off;
    logic [31:0]   rdWord;
    logic          unusedAddrBits;

    logic [7:0]    kbdDout;
    logic [CW-1:0] kbdCount;
    logic          kbdFull, kbdEmpty, kbdPop;

    logic [31:0]   dataout_q, dataout_d;
    logic [15:0]   led_q, led_d;
    logic [31:0]   timerMs_q, timerMs_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   cycle_q, cycle_d;
    logic          overflow_q, overflow_d;

    // Only addr[31:20] and addr[4:0] decode; the rest of the window aliases.
    assign unusedAddrBits = ^addr[19:5];

    assign sel     = (addr[31:20] == BASE);
    assign rdEn    = re && sel;
    assign wrEn    = we && sel;
    assign off     = addr[4:2];
    assign timerWr = wrEn && (off == OFF_TIMER_MS);
    assign tick    = (presc_q == PRESC_MAX);
    assign kbdPop  = rdEn && (off == OFF_KBD_DATA) && !kbdEmpty;

    mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (kbd_valid),
        .din   (kbd_code),
        .pop   (kbdPop),
        .dout  (kbdDout),
        .count (kbdCount),
        .full  (kbdFull),
        .empty (kbdEmpty)
    );

`ifdef MMIO_TIMER_CMP_EN
    logic [31:0] cmp_q, cmp_d;
    logic        irq_q, irq_d;

    // A CMP store clears irq even if the compare would fire in the same cycle.
    always_comb begin
        cmp_d = cmp_q;
        irq_d = irq_q;
        if (tick && !timerWr && ((timerMs_q + 32'd1) == cmp_q)) irq_d = 1'b1;
        if (wrEn && (off == OFF_CMP)) begin
            cmp_d = storeMerge(cmp_q, datain, memop[1:0], addr[1:0]);
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmp_q <= 32'hFFFF_FFFF;
            irq_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdWord = '0;
        case (off)
            OFF_KBD_DATA: rdWord = kbdEmpty ? 32'h0 : {23'b0, 1'b1, kbdDout};
            OFF_KBD_STAT: rdWord = 32'({overflow_q, kbdCount});
            OFF_TIMER_MS: rdWord = timerMs_q;
            OFF_LED:      rdWord = {16'b0, led_q};
            OFF_CYCLE:    rdWord = cycle_q;
`ifdef MMIO_TIMER_CMP_EN
            OFF_CMP:      rdWord = cmp_q;
`endif
            default:      rdWord = '0;
        endcase
    end

    always_comb begin
        dataout_d  = dataout_q;
        led_d      = led_q;
        timerMs_d  = timerMs_q;
        presc_d    = presc_q + 1'b1;
        cycle_d    = cycle_q + 32'd1;
        overflow_d = overflow_q;

        if (rdEn) dataout_d = extend(rdWord, memop, addr[1:0]);

        if (wrEn && (off == OFF_LED))
            led_d = 16'(storeMerge({16'b0, led_q}, datain, memop[1:0], addr[1:0]));

        if (tick) begin
            presc_d   = '0;
            timerMs_d = timerMs_q + 32'd1;
        end
        if (timerWr) begin
            timerMs_d = storeMerge(timerMs_q, datain, memop[1:0], addr[1:0]);
            presc_d   = '0;
        end

        // A fresh drop outranks the clear-on-read so it is never lost.
        if (rdEn && (off == OFF_KBD_STAT)) overflow_d = 1'b0;
        if (kbd_valid && kbdFull && !kbdPop) overflow_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dataout_q  <= '0;
            led_q      <= '0;
            timerMs_q  <= '0;
            presc_q    <= '0;
            cycle_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            dataout_q  <= dataout_d;
            led_q      <= led_d;
            timerMs_q  <= timerMs_d;
            presc_q    <= presc_d;
            cycle_q    <= cycle_d;
            overflow_q <= overflow_d;
        end
    end

    assign dataout = dataout_q;
    assign led     = led_q;

endmodule

// File: tb/tb_mmio_resp.sv
// Self-checking bench for mmio_resp (CLK_HZ=4000 so one ms is four clocks).
// Compile with or without MMIO_TIMER_CMP_EN; irq/CMP expectations follow the macro.
`timescale 1ns/1ps
module tb_mmio_resp;

    localparam int DEPTH = 16;

    localparam logic [31:0] A_KBD   = 32'h0020_0000;
    localparam logic [31:0] A_STAT  = 32'h0020_0004;
    localparam logic [31:0] A_TIMER = 32'h0020_0008;
    localparam logic [31:0] A_LED   = 32'h0020_000C;
    localparam logic [31:0] A_CYCLE = 32'h0020_0010;
    localparam logic [31:0] A_CMP   = 32'h0020_0014;
    localparam logic [31:0] A_UNMAP = 32'h0020_0018;
    localparam logic [31:0] A_OTHER = 32'h0030_000C;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

`ifdef MMIO_TIMER_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] datain = '0;
    logic [31:0] dataout;
    logic [2:0]  memop = LW;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [7:0]  kbd_code = '0;
    logic        kbd_valid = 1'b0;
    logic [15:0] led;
    logic        irq;

    int          nApplied = 0;
    int          nMiscompare = 0;
    logic [31:0] expQ[$];
    logic [7:0]  kbdModel[$];

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [2:0]  op;
        logic [31:0] d;
        logic        chk;
        logic [31:0] expData;
        logic [15:0] expLed;
    } vec_t;

    vec_t vecs[19];

    mmio_resp #(.BASE(12'h002), .CLK_HZ(4000), .FIFO_DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .addr      (addr),
        .datain    (datain),
        .dataout   (dataout),
        .memop     (memop),
        .we        (we),
        .re        (re),
        .kbd_code  (kbd_code),
        .kbd_valid (kbd_valid),
        .led       (led),
        .irq       (irq)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compareValue(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        nApplied++;
        if (actual !== expected) begin
            nMiscompare++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name);
        logic [31:0] e;
        if (expQ.size() == 0) begin
            compareValue({name, " (scoreboard empty)"}, dataout, 32'hxxxx_xxxx);
        end else begin
            e = expQ.pop_front();
            compareValue(name, dataout, e);
        end
    endtask

    // Called just after an edge; drives one bus cycle and samples 1 ns past the next edge.
    task automatic applyStimulus(input string name, input logic w, input logic r,
                                 input logic [31:0] a, input logic [2:0] op,
                                 input logic [31:0] d, input logic kv,
                                 input logic [7:0] kc, input logic chk,
                                 input logic [31:0] expv);
        we = w; re = r; addr = a; memop = op; datain = d;
        kbd_valid = kv; kbd_code = kc;
        if (chk) expQ.push_back(expv);
        @(posedge clock);
        #1;
        if (chk) checkOutput(name);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [2:0] op,
                      input logic [31:0] expv);
        applyStimulus(name, 1'b0, 1'b1, a, op, 32'h0, 1'b0, 8'h0, 1'b1, expv);
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d);
        applyStimulus("store", 1'b1, 1'b0, a, op, d, 1'b0, 8'h0, 1'b0, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus("idle", 1'b0, 1'b0, 32'h0, LW, 32'h0, 1'b0, 8'h0, 1'b0, 32'h0);
    endtask

    task automatic pushCode(input logic [7:0] c);
        applyStimulus("push", 1'b0, 1'b0, 32'h0, LW, 32'h0, 1'b1, c, 1'b0, 32'h0);
        if (kbdModel.size() < DEPTH) kbdModel.push_back(c);
    endtask

    task automatic rdKbd(input string name);
        logic [31:0] e;
        if (kbdModel.size() != 0) e = {23'b0, 1'b1, kbdModel.pop_front()};
        else e = 32'h0;
        rd(name, A_KBD, LW, e);
    endtask

    function automatic logic [31:0] statWord(input logic ovf);
        return 32'({ovf, 5'(kbdModel.size())});
    endfunction

    task automatic doReset();
        reset = 1'b1;
        we = 1'b0; re = 1'b0; kbd_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        kbdModel.delete();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, A_LED,         LW,     32'h1234_ABCD, 1'b0, 32'h0,         16'hABCD};
        vecs[1]  = '{1'b1, 1'b0, A_LED + 1,     LB,     32'hABCD_EFEE, 1'b0, 32'h0,         16'hEECD};
        vecs[2]  = '{1'b0, 1'b1, A_LED,         LW,     32'h0,         1'b1, 32'h0000_EECD, 16'hEECD};
        vecs[3]  = '{1'b0, 1'b1, A_LED + 1,     LB,     32'h0,         1'b1, 32'hFFFF_FFEE, 16'hEECD};
        vecs[4]  = '{1'b0, 1'b1, A_LED + 1,     LBU,    32'h0,         1'b1, 32'h0000_00EE, 16'hEECD};
        vecs[5]  = '{1'b0, 1'b1, A_LED,         LB,     32'h0,         1'b1, 32'hFFFF_FFCD, 16'hEECD};
        vecs[6]  = '{1'b0, 1'b1, A_LED,         LH,     32'h0,         1'b1, 32'hFFFF_EECD, 16'hEECD};
        vecs[7]  = '{1'b0, 1'b1, A_LED,         LHU,    32'h0,         1'b1, 32'h0000_EECD, 16'hEECD};
        vecs[8]  = '{1'b0, 1'b1, A_LED + 2,     LHU,    32'h0,         1'b1, 32'h0000_0000, 16'hEECD};
        vecs[9]  = '{1'b1, 1'b0, A_LED,         LH,     32'h1234_7F01, 1'b0, 32'h0,         16'h7F01};
        vecs[10] = '{1'b0, 1'b1, A_LED,         LH,     32'h0,         1'b1, 32'h0000_7F01, 16'h7F01};
        vecs[11] = '{1'b1, 1'b0, A_LED + 2,     LB,     32'h0000_0055, 1'b0, 32'h0,         16'h7F01};
        vecs[12] = '{1'b0, 1'b1, A_LED,         LW,     32'h0,         1'b1, 32'h0000_7F01, 16'h7F01};
        vecs[13] = '{1'b1, 1'b0, A_UNMAP,       LW,     32'hFFFF_FFFF, 1'b0, 32'h0,         16'h7F01};
        vecs[14] = '{1'b0, 1'b1, A_UNMAP,       LW,     32'h0,         1'b1, 32'h0000_0000, 16'h7F01};
        vecs[15] = '{1'b0, 1'b1, A_LED,         3'b011, 32'h0,         1'b1, 32'h0000_7F01, 16'h7F01};
        vecs[16] = '{1'b1, 1'b1, A_LED,         LW,     32'h0000_BEEF, 1'b1, 32'h0000_7F01, 16'hBEEF};
        vecs[17] = '{1'b0, 1'b1, A_LED,         LW,     32'h0,         1'b1, 32'h0000_BEEF, 16'hBEEF};
        vecs[18] = '{1'b1, 1'b1, A_OTHER,       LW,     32'hFFFF_FFFF, 1'b1, 32'h0000_BEEF, 16'hBEEF};

        // Power-on reset state.
        @(posedge clock); #1;
        compareValue("reset dataout", dataout, 32'h0);
        compareValue("reset led", {16'h0, led}, 32'h0);
        compareValue("reset irq", {31'h0, irq}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Edge counts below are relative to reset release; the timer ticks every 4th edge.
        rd("cycle after reset", A_CYCLE, LW, 32'd0);
        wr(A_CMP, LW, 32'd2);
        rd("stat after reset", A_STAT, LW, 32'h0);
        rd("led after reset", A_LED, LW, 32'h0);
        idle(3);
        compareValue("irq before compare", {31'h0, irq}, 32'h0);
        idle(1);
        compareValue("irq at compare", {31'h0, irq}, {31'h0, CMP_EN});
        idle(4);
        rd("timer after 12 edges", A_TIMER, LW, 32'd3);
        rd("cmp readback", A_CMP, LW, CMP_EN ? 32'd2 : 32'd0);
        rd("cycle after 14 edges", A_CYCLE, LW, 32'd14);
        compareValue("irq level held", {31'h0, irq}, {31'h0, CMP_EN});
        wr(A_CMP, LW, 32'h100);
        compareValue("irq cleared by cmp store", {31'h0, irq}, 32'h0);
        wr(A_TIMER, LW, 32'hFFFF_FFFF);
        idle(2);
        rd("timer loaded", A_TIMER, LW, 32'hFFFF_FFFF);
        rd("timer before wrap", A_TIMER, LW, 32'hFFFF_FFFF);
        rd("timer wrapped", A_TIMER, LW, 32'h0);

        // Lane and decode vectors on the LED register.
        for (int i = 0; i < 19; i++) begin
            applyStimulus($sformatf("vec%0d dataout", i), vecs[i].w, vecs[i].r, vecs[i].a,
                          vecs[i].op, vecs[i].d, 1'b0, 8'h0, vecs[i].chk, vecs[i].expData);
            compareValue($sformatf("vec%0d led", i), {16'h0, led}, {16'h0, vecs[i].expLed});
        end

        // FIFO: single entry, empty pop, push without bypass.
        doReset();
        pushCode(8'h1C);
        rdKbd("kbd first pop");
        rdKbd("kbd pop empty");
        applyStimulus("kbd no bypass", 1'b0, 1'b1, A_KBD, LW, 32'h0, 1'b1, 8'hAA, 1'b1, 32'h0);
        kbdModel.push_back(8'hAA);
        rdKbd("kbd after push");

        // FIFO: overflow, clear-on-read, simultaneous pop and push at full.
        for (int i = 0; i <= DEPTH; i++) pushCode(8'(8'h40 + i));
        rd("stat overflow", A_STAT, LW, statWord(1'b1));
        rd("stat cleared", A_STAT, LW, statWord(1'b0));
        applyStimulus("kbd pop+push full", 1'b0, 1'b1, A_KBD, LW, 32'h0, 1'b1, 8'h77,
                      1'b1, {23'b0, 1'b1, kbdModel[0]});
        void'(kbdModel.pop_front());
        kbdModel.push_back(8'h77);
        rd("stat after pop+push", A_STAT, LW, statWord(1'b0));
        for (int i = 0; i < DEPTH; i++) rdKbd($sformatf("kbd drain %0d", i));
        rdKbd("kbd drained");
        rd("stat drained", A_STAT, LW, statWord(1'b0));

        // Reset asserted in the middle of a load.
        pushCode(8'h21);
        pushCode(8'h22);
        wr(A_LED, LW, 32'h0000_FFFF);
        rd("led before reset", A_LED, LW, 32'h0000_FFFF);
        re = 1'b1; addr = A_KBD; memop = LW;
        #3;
        reset = 1'b1;
        #1;
        compareValue("midrun dataout", dataout, 32'h0);
        compareValue("midrun led", {16'h0, led}, 32'h0);
        compareValue("midrun irq", {31'h0, irq}, 32'h0);
        @(posedge clock); #1;
        re = 1'b0;
        reset = 1'b0;
        kbdModel.delete();
        rd("cycle restart", A_CYCLE, LW, 32'd0);
        rd("stat after midrun reset", A_STAT, LW, 32'h0);
        rd("cycle counting", A_CYCLE, LW, 32'd2);
        rdKbd("kbd after midrun reset");

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
        $finish;
    end

endmodule
